// File: rtl/mux_sched_pkg.sv
// Shared types for the gamma-window multiplex scheduler: FSM states, network id,
// and a one-hot helper used for grant and result-strobe encoding.
package mux_sched_pkg;

  localparam int NUM_NETS = 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;

  typedef logic net_id_t;

  function automatic logic [NUM_NETS-1:0] net_onehot(input net_id_t n);
    return NUM_NETS'(1) << n;
  endfunction

endpackage

// File: rtl/multiplex_scheduler_if.sv
// Bundle between the scheduler, the two network front-ends and the multiplexed column.
// master = scheduler side, slave = network/column side.
interface multiplex_scheduler_if #(
  parameter int Q  = 2,
  parameter int TW = 5
);
  import mux_sched_pkg::*;

  logic [NUM_NETS-1:0] req;
  logic [NUM_NETS-1:0] gnt;
  logic                sel;
  logic                col_grst;
  logic [Q-1:0]        col_spikes;
  logic [NUM_NETS-1:0] res_valid;
  logic [Q-1:0]        res_spikes;
  logic [Q*TW-1:0]     res_time;
  logic                busy;

  modport master (
    input  req, col_spikes,
    output gnt, sel, col_grst, res_valid, res_spikes, res_time, busy
  );

  modport slave (
    output req, col_spikes,
    input  gnt, sel, col_grst, res_valid, res_spikes, res_time, busy
  );

endinterface

// File: rtl/multiplex_scheduler_spike_time_latch.sv
// First-spike time capture for one column neuron; idles at the saturated
// "no spike" value GAMMA_LEN until a spike is seen while enabled.
module spike_time_latch #(
  parameter int GAMMA_LEN = 16,
  parameter int TW        = $clog2(GAMMA_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          spike,
  input  logic [TW-1:0] cnt,
  output logic          fired,
  output logic [TW-1:0] t_first
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fired   <= 1'b0;
      t_first <= TW'(GAMMA_LEN);
    end else if (clr) begin
      fired   <= 1'b0;
      t_first <= TW'(GAMMA_LEN);
    end else if (en && spike && !fired) begin
      fired   <= 1'b1;
      t_first <= cnt;
    end
  end

endmodule

// File: rtl/multiplex_scheduler.sv
// Gamma-window scheduler time-sharing one learning column between two networks.
// Define MUX_SCHED_FIXED_PRIO_EN for fixed priority (network 0 wins ties); default is round-robin.
module multiplex_scheduler
  import mux_sched_pkg::*;
#(
  parameter int Q         = 2,
  parameter int GAMMA_LEN = 16
) (
  input logic                  clk,
  input logic                  rst,
  multiplex_scheduler_if.master bus
);

  localparam int TW = $clog2(GAMMA_LEN + 1);

  sched_state_t        state, state_nxt;
  logic [TW-1:0]       cnt, cnt_nxt;
  logic [NUM_NETS-1:0] gnt_q, gnt_nxt;
  net_id_t             sel_q, sel_nxt;
  net_id_t             win;
  logic                clr, en;

`ifdef MUX_SCHED_FIXED_PRIO_EN
  always_comb win = bus.req[0] ? 1'b0 : 1'b1;
`else
  net_id_t rr;

  // Tie goes to rr; a lone requester wins outright.
  always_comb begin
    if (&bus.req) win = rr;
    else          win = bus.req[0] ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                rr <= 1'b0;
    else if (state == FLUSH) rr <= ~sel_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      gnt_q <= '0;
      sel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gnt_q <= gnt_nxt;
      sel_q <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt_q;
    sel_nxt   = sel_q;
    clr       = 1'b0;
    en        = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = RUN;
          sel_nxt   = win;
          gnt_nxt   = net_onehot(win);
          cnt_nxt   = '0;
          clr       = 1'b1;
        end
      end
      RUN: begin
        en      = 1'b1;
        cnt_nxt = cnt + TW'(1);
        if (cnt == TW'(GAMMA_LEN - 1)) begin
          state_nxt = FLUSH;
          gnt_nxt   = '0;
        end
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-neuron capture; the spike on the last RUN cycle is sampled on the RUN->FLUSH edge.
  for (genvar q = 0; q < Q; q++) begin : g_latch
    spike_time_latch #(.GAMMA_LEN(GAMMA_LEN), .TW(TW)) u_latch (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .spike   (bus.col_spikes[q]),
      .cnt     (cnt),
      .fired   (bus.res_spikes[q]),
      .t_first (bus.res_time[q*TW +: TW])
    );
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.col_grst  = (state == FLUSH);
  assign bus.res_valid = (state == FLUSH) ? net_onehot(sel_q) : '0;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_multiplex_scheduler.sv
// Directed bench for multiplex_scheduler with hand-computed window results.
module tb_multiplex_scheduler;

  localparam int Q  = 2;
  localparam int GL = 16;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst;

  multiplex_scheduler_if #(.Q(Q), .TW(TW)) bus ();

  multiplex_scheduler #(.Q(Q), .GAMMA_LEN(GL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] tpack(input int t1, input int t0);
    return {5'(t1), 5'(t0)};
  endfunction

  // Starts from IDLE: grant edge, 16 RUN cycles, FLUSH, then one IDLE cycle.
  task automatic run_window(input string tag, input logic [1:0] r, input bit hold,
                            input logic [1:0] eg, input logic [15:0] sp0, input logic [15:0] sp1,
                            input logic [1:0] es, input logic [9:0] et, output time tf);
    bus.req = r;
    step();
    if (!hold) bus.req = 2'b00;
    check($sformatf("%s.sel", tag), bus.sel, eg[1]);
    check($sformatf("%s.busy_run", tag), bus.busy, 1'b1);
    for (int i = 0; i < GL; i++) begin
      check($sformatf("%s.gnt%0d", tag, i), bus.gnt, eg);
      bus.col_spikes = {sp1[i], sp0[i]};
      step();
    end
    bus.col_spikes = '0;
    tf = $time;
    check($sformatf("%s.fl_gnt", tag), bus.gnt, 2'b00);
    check($sformatf("%s.fl_grst", tag), bus.col_grst, 1'b1);
    check($sformatf("%s.fl_valid", tag), bus.res_valid, eg);
    check($sformatf("%s.fl_spikes", tag), bus.res_spikes, es);
    check($sformatf("%s.fl_time", tag), bus.res_time, et);
    check($sformatf("%s.fl_busy", tag), bus.busy, 1'b1);
    check($sformatf("%s.fl_sel", tag), bus.sel, eg[1]);
    step();
    check($sformatf("%s.id_valid", tag), bus.res_valid, 2'b00);
    check($sformatf("%s.id_grst", tag), bus.col_grst, 1'b0);
    check($sformatf("%s.id_busy", tag), bus.busy, 1'b0);
    check($sformatf("%s.id_time", tag), bus.res_time, et);
    check($sformatf("%s.id_spikes", tag), bus.res_spikes, es);
    check($sformatf("%s.id_sel", tag), bus.sel, eg[1]);
  endtask

  task automatic check_reset_vals(input string tag);
    check($sformatf("%s.gnt", tag), bus.gnt, 2'b00);
    check($sformatf("%s.sel", tag), bus.sel, 1'b0);
    check($sformatf("%s.grst", tag), bus.col_grst, 1'b0);
    check($sformatf("%s.valid", tag), bus.res_valid, 2'b00);
    check($sformatf("%s.spikes", tag), bus.res_spikes, 2'b00);
    check($sformatf("%s.time", tag), bus.res_time, tpack(16, 16));
    check($sformatf("%s.busy", tag), bus.busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  time t_a, t_b, t_c;
  logic [1:0] g2_exp;

  initial begin
    rst            = 1'b1;
    bus.req        = 2'b00;
    bus.col_spikes = '0;
    step();
    step();
    check_reset_vals("rst0");
    rst = 1'b0;
    step();

    // Single requester, neuron 1 fires on RUN cycle 3.
    run_window("t1", 2'b01, 1'b0, 2'b01, 16'h0000, 16'h0008, 2'b10, tpack(3, 16), t_a);

    // Both requesting continuously from a fresh reset.
    do_reset();
`ifdef MUX_SCHED_FIXED_PRIO_EN
    g2_exp = 2'b01;
`else
    g2_exp = 2'b10;
`endif
    run_window("t2a", 2'b11, 1'b1, 2'b01,  16'h0, 16'h0, 2'b00, tpack(16, 16), t_a);
    run_window("t2b", 2'b11, 1'b1, g2_exp, 16'h0, 16'h0, 2'b00, tpack(16, 16), t_b);
    run_window("t2c", 2'b11, 1'b1, 2'b01,  16'h0, 16'h0, 2'b00, tpack(16, 16), t_c);
    bus.req = 2'b00;
    check("t2.gap_ab", 32'(t_b - t_a), 32'd180);
    check("t2.gap_bc", 32'(t_c - t_b), 32'd180);
    step();

    // Only the first of several spikes counts; a last-cycle spike is still captured.
    run_window("t3a", 2'b01, 1'b0, 2'b01, 16'h8024, 16'h0, 2'b01, tpack(16, 2), t_a);
    run_window("t3b", 2'b01, 1'b0, 2'b01, 16'h8000, 16'h0, 2'b01, tpack(16, 15), t_a);

    // Silent window still strobes and clears the previous result.
    run_window("t4", 2'b01, 1'b0, 2'b01, 16'h0, 16'h0, 2'b00, tpack(16, 16), t_a);

    // Abort a window from network 1 at RUN cycle 7.
    bus.req = 2'b10;
    step();
    bus.req = 2'b00;
    for (int i = 0; i < 7; i++) begin
      bus.col_spikes = {1'b0, (i == 2)};
      step();
    end
    bus.col_spikes = '0;
    check("t5.pre_gnt", bus.gnt, 2'b10);
    check("t5.pre_spikes", bus.res_spikes, 2'b01);
    check("t5.pre_time", bus.res_time, tpack(16, 2));
    rst = 1'b1;
    #1;
    check_reset_vals("t5.async");
    step();
    check("t5.hold_valid", bus.res_valid, 2'b00);
    check("t5.hold_grst", bus.col_grst, 1'b0);
    rst = 1'b0;
    step();
    check_reset_vals("t5.post");
    run_window("t5b", 2'b11, 1'b0, 2'b01, 16'h0, 16'h0, 2'b00, tpack(16, 16), t_a);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multiplex_scheduler.md
# multiplex_scheduler

Gamma-window scheduler that time-shares one learning column between two spike-producing networks. It arbitrates between the two networks' wave requests and grants one network per gamma window. It drives the input-select and gamma-reset of the multiplexed column, and captures each column neuron's first-spike time. It then returns the per-window result to the granted network. It sits between the two network front-ends and the multiplexed column's replay-buffer select and `grst` inputs.

## Interface
Parameters:
- `Q`, 2, number of column neurons, matching the column's `Q`.
- `GAMMA_LEN`, 16, cycles per gamma window; legal range 2..255.
- `TW`, `$clog2(GAMMA_LEN+1)`, localparam, spike-time width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  2  per-network wave request; level, held by requester until granted.
- `gnt`  out  2  one-hot grant; held for the whole window.
- `sel`  out  1  network index feeding the column input mux.
- `col_grst`  out  1  gamma reset to the column; one-cycle pulse.
- `col_spikes`  in  Q  column `output_spikes`.
- `res_valid`  out  2  one-cycle per-network result strobe.
- `res_spikes`  out  Q  neuron fired during the window.
- `res_time`  out  Q×TW  first-spike cycle offset per neuron.
- `busy`  out  1  high in RUN or FLUSH.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- **IDLE**
  - If any `req` bit is set, pick a winner, register `gnt`/`sel`, clear `cnt` and the capture registers, then go to RUN.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Round-robin pointer `rr`. If both requests are set, network `rr` wins.
  - After a window completes, `rr` becomes the other network.
  - A single requester always wins, regardless of `rr`.
- **RUN**
  - `cnt` increments each cycle from 0.
  - For each neuron `q`, capture the first cycle `col_spikes[q]`=1: `res_time[q]`←`cnt`, `res_spikes[q]`←1.
  - Later spikes from the same neuron are ignored.
  - When `cnt==GAMMA_LEN-1`, go to FLUSH. The spike on that last cycle is still captured.
- **FLUSH** (one cycle)
  - `gnt`←0 and `col_grst`=1.
  - `res_valid[winner]`=1, with `res_spikes`/`res_time` stable.
  - Update `rr`, then return to IDLE.
- Non-firing neuron: `res_spikes[q]`=0 and `res_time[q]`=`GAMMA_LEN` (saturated "no spike").
- Dropping `req` during RUN has no effect; the window always runs to completion.
- Raising `req` for the other network during RUN is held pending and served from IDLE.
- `res_spikes`/`res_time` keep their values until the next grant clears them.

## Timing
- **Reset values:** state=IDLE, `gnt`=0, `sel`=0, `col_grst`=0, `res_valid`=0, `res_spikes`=0, `res_time`=all `GAMMA_LEN`, `busy`=0, `rr`=0.
- **Reset mid-window:** abort immediately. No `res_valid` and no `col_grst` pulse; the column relies on its own reset.
- **Grant latency:**
  - `req` sampled high at edge N → `gnt`/`sel`/`busy` high after edge N.
  - RUN covers cycles N+1..N+GAMMA_LEN.
  - FLUSH occupies cycle N+GAMMA_LEN+1.
- **Throughput:** one mandatory IDLE cycle between windows, so back-to-back windows repeat every GAMMA_LEN+2 cycles.
- **Capture:** `col_spikes` is sampled registered, with no combinational path to outputs. `res_time` equals the RUN-cycle index (0-based) of the sample.
- `sel` changes only on the IDLE→RUN edge. It holds during FLUSH and IDLE.

## Configuration
- `MUX_SCHED_FIXED_PRIO_EN`
  - **Defined:** network 0 always wins simultaneous requests, and `rr` is removed.
  - **Undefined (default):** round-robin as above.

## Structure
- Package `mux_sched_pkg` holds:
  - state enum `sched_state_t` {IDLE, RUN, FLUSH};
  - `net_id_t` (1 bit);
  - `NUM_NETS`=2.
- Sub-module `spike_time_latch`, one instance per neuron:
  - inputs: clear, enable, spike, `cnt`;
  - outputs: fired flag and first-spike time;
  - holds its own saturation default.
- Top level contains the FSM, arbiter, `cnt`, and output registers.

## Test plan
- Reset, then `req`=2'b01 only; `col_spikes[1]` pulses at RUN cycle 3 → `gnt`=01 for 16 cycles; FLUSH shows `col_grst`=1, `res_valid`=01, `res_spikes`=2'b10, `res_time`={3,16}.
- `req`=2'b11 held continuously → grants alternate 01, 10, 01. Each `res_valid` arrives 18 cycles apart.
- Neuron 0 spikes at RUN cycles 2, 5, and 15 → `res_time[0]`=2. A separate run with the only spike at cycle 15 (last) → `res_time[0]`=15, `res_spikes[0]`=1.
- No spikes in a window → `res_spikes`=0, `res_time`={16,16}, `res_valid` still pulses.
- Assert `rst` at RUN cycle 7 → all outputs return to reset values asynchronously, with no `res_valid`. After release, `req`=11 grants network 0.
- With `MUX_SCHED_FIXED_PRIO_EN` defined, `req`=11 held → network 0 is granted on every window.
